// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcode and immediate-type constants for the immediate generator
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_Z    = 3'd6;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode to immediate/type/illegal/pc-relative decode
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit CSR_IMM = 1'b1
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal,
    output logic            is_pcrel
);

    localparam bit RV64 = (XLEN == 64);

    // Every format fits in 32 bits; widening to XLEN is a single sign extension below.
    logic [31:0] imm32;

    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        is_pcrel = 1'b0;
        case (instruction[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE: begin
                imm_type = IMM_I;
                imm32    = sext12(instruction[31:20]);
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm32    = sext12({instruction[31:25], instruction[11:7]});
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                is_pcrel = 1'b1;
                imm32    = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            end
            OPC_LUI: begin
                imm_type = IMM_U;
                imm32    = {instruction[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                imm_type = IMM_U;
                is_pcrel = 1'b1;
                imm32    = {instruction[31:12], 12'b0};
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                is_pcrel = 1'b1;
                imm32    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            end
            OPC_OP: begin
                imm_type = IMM_NONE;
            end
            OPC_SYSTEM: begin
                if (CSR_IMM && instruction[14]) begin
                    imm_type = IMM_Z;
                    imm32    = {27'd0, instruction[19:15]};
                end
            end
            OPC_OPIMM32: begin
                if (RV64) begin
                    imm_type = IMM_I;
                    imm32    = sext12(instruction[31:20]);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP32: begin
                illegal = !RV64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with PC-relative target and valid/ready flow
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int STAGES  = 1,
    parameter bit CSR_IMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] d_target;
    logic [2:0]      d_type;
    logic            d_illegal;
    logic            d_pcrel;

    imm_decode #(
        .XLEN    (XLEN),
        .CSR_IMM (CSR_IMM)
    ) u_decode (
        .instruction (instruction),
        .imm         (d_imm),
        .imm_type    (d_type),
        .illegal     (d_illegal),
        .is_pcrel    (d_pcrel)
    );

    assign d_target = d_pcrel ? (pc + d_imm) : '0;

    logic            v_q     [STAGES];
    logic [XLEN-1:0] imm_q   [STAGES];
    logic [XLEN-1:0] tgt_q   [STAGES];
    logic [2:0]      type_q  [STAGES];
    logic            ill_q   [STAGES];
    logic [STAGES-1:0] vv;
    logic [STAGES-1:0] ld;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic            s_v;
        logic [XLEN-1:0] s_imm;
        logic [XLEN-1:0] s_tgt;
        logic [2:0]      s_type;
        logic            s_ill;

        if (k == 0) begin : g_head
            assign s_v    = in_valid;
            assign s_imm  = d_imm;
            assign s_tgt  = d_target;
            assign s_type = d_type;
            assign s_ill  = d_illegal;
        end else begin : g_tail
            assign s_v    = v_q[k-1];
            assign s_imm  = imm_q[k-1];
            assign s_tgt  = tgt_q[k-1];
            assign s_type = type_q[k-1];
            assign s_ill  = ill_q[k-1];
        end

        assign vv[k] = v_q[k];
        // Unrolled ready chain: a stage loads if the consumer takes or any stage from here on is empty.
        assign ld[k] = out_ready || !(&vv[STAGES-1:k]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q[k]    <= 1'b0;
                imm_q[k]  <= '0;
                tgt_q[k]  <= '0;
                type_q[k] <= IMM_NONE;
                ill_q[k]  <= 1'b0;
            end else begin
                if (flush) begin
                    v_q[k] <= 1'b0;
                end else if (ld[k]) begin
                    v_q[k] <= s_v;
                end
                if (ld[k] && s_v) begin
                    imm_q[k]  <= s_imm;
                    tgt_q[k]  <= s_tgt;
                    type_q[k] <= s_type;
                    ill_q[k]  <= s_ill;
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign imm       = out_valid ? imm_q[STAGES-1]  : '0;
    assign target    = out_valid ? tgt_q[STAGES-1]  : '0;
    assign imm_type  = out_valid ? type_q[STAGES-1] : IMM_NONE;
    assign illegal   = out_valid ? ill_q[STAGES-1]  : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] pc;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_imm, a_target;
    logic [2:0]  a_type;
    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm, b_target;
    logic [2:0]  b_type;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .CSR_IMM(1'b1)) u_a (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (a_in_ready),
        .instruction (instruction),
        .pc          (pc[31:0]),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready),
        .imm         (a_imm),
        .target      (a_target),
        .imm_type    (a_type),
        .illegal     (a_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(2), .CSR_IMM(1'b0)) u_b (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (b_in_ready),
        .instruction (instruction),
        .pc          (pc),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready),
        .imm         (b_imm),
        .target      (b_target),
        .imm_type    (b_type),
        .illegal     (b_illegal)
    );

    logic [63:0] o_imm [2];
    logic [63:0] o_tgt [2];
    logic [2:0]  o_ty  [2];
    logic        o_ill [2];
    logic        o_vld [2];
    logic        o_rdy [2];

    assign o_imm[0] = {32'd0, a_imm};
    assign o_tgt[0] = {32'd0, a_target};
    assign o_ty[0]  = a_type;
    assign o_ill[0] = a_illegal;
    assign o_vld[0] = a_out_valid;
    assign o_rdy[0] = a_in_ready;
    assign o_imm[1] = b_imm;
    assign o_tgt[1] = b_target;
    assign o_ty[1]  = b_type;
    assign o_ill[1] = b_illegal;
    assign o_vld[1] = b_out_valid;
    assign o_rdy[1] = b_in_ready;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [31:0] acc;
    } ent_t;

    ent_t q [2][$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   edge_n = 0;
    int   pop_cnt [2];
    bit   saw_stall;
    logic [6:0] opc_tab [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int xl(input int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic int st(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit cs(input int d);
        return d == 0;
    endfunction

    function automatic longint sx(input longint raw, input int bits);
        return (raw >= (longint'(1) << (bits - 1))) ? raw - (longint'(1) << bits) : raw;
    endfunction

    // Reference decode: field values assembled with arithmetic, then wrapped to XLEN.
    function automatic void ref_dec(input logic [31:0] i, input logic [63:0] p, input int xlen,
                                    input bit csr, output logic [63:0] imm, output logic [63:0] tgt,
                                    output logic [2:0] ty, output logic ill);
        longint v;
        bit     pcrel;
        logic [63:0] mask;
        v = 0; ty = 3'd0; ill = 1'b0; pcrel = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: begin ty = 3'd1; v = sx(longint'(i[31:20]), 12); end
            7'h23: begin ty = 3'd2; v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
            7'h63: begin
                ty = 3'd3; pcrel = 1'b1;
                v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                       longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            end
            7'h37: begin ty = 3'd4; v = sx(longint'(i[31:12]) * 4096, 32); end
            7'h17: begin ty = 3'd4; pcrel = 1'b1; v = sx(longint'(i[31:12]) * 4096, 32); end
            7'h6F: begin
                ty = 3'd5; pcrel = 1'b1;
                v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                       longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            end
            7'h33: ;
            7'h73: if (csr && i[14]) begin ty = 3'd6; v = longint'(i[19:15]); end
            7'h1B: if (xlen == 64) begin ty = 3'd1; v = sx(longint'(i[31:20]), 12); end
                   else ill = 1'b1;
            7'h3B: ill = (xlen != 64);
            default: ill = 1'b1;
        endcase
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        imm  = 64'(v) & mask;
        tgt  = pcrel ? ((p + 64'(v)) & mask) : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    // One clock: compare outputs against the model at negedge, then advance the model at posedge.
    task automatic tick();
        bit acc [2];
        bit pop [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit er, ev;
            logic [63:0] ei, et;
            logic [2:0]  ety;
            logic        eil;
            er = (q[d].size() < st(d)) || out_ready;
            ev = (q[d].size() > 0) && (int'(q[d][0].acc) + st(d) - 1 <= edge_n);
            if (ev) ref_dec(q[d][0].inst, q[d][0].pc, xl(d), cs(d), ei, et, ety, eil);
            else begin ei = '0; et = '0; ety = '0; eil = 1'b0; end
            check($sformatf("in_ready[%0d]", d), 64'(o_rdy[d]), 64'(er));
            check($sformatf("out_valid[%0d]", d), 64'(o_vld[d]), 64'(ev));
            check($sformatf("imm[%0d]", d), o_imm[d], ei);
            check($sformatf("target[%0d]", d), o_tgt[d], et);
            check($sformatf("imm_type[%0d]", d), 64'(o_ty[d]), 64'(ety));
            check($sformatf("illegal[%0d]", d), 64'(o_ill[d]), 64'(eil));
            if (d == 1 && !o_rdy[1]) saw_stall = 1'b1;
            acc[d] = in_valid && er && !flush && !rst;
            pop[d] = ev && out_ready;
        end
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            if (flush || rst) q[d].delete();
            else begin
                if (pop[d]) begin void'(q[d].pop_front()); pop_cnt[d]++; end
                if (acc[d]) q[d].push_back('{inst: instruction, pc: pc, acc: 32'(edge_n)});
            end
        end
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (4) tick();
    endtask

    task automatic directed(input logic [31:0] inst, input logic [63:0] p,
                            input logic [63:0] ai, input logic [63:0] at, input logic [2:0] aty,
                            input logic ail, input logic [63:0] bi, input logic [63:0] bt,
                            input logic [2:0] bty, input logic bil);
        instruction = inst; pc = p; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        tick();
        in_valid = 1'b0;
        check("dir_a_valid", 64'(o_vld[0]), 64'd1);
        check("dir_a_imm", o_imm[0], ai);
        check("dir_a_target", o_tgt[0], at);
        check("dir_a_type", 64'(o_ty[0]), 64'(aty));
        check("dir_a_illegal", 64'(o_ill[0]), 64'(ail));
        check("dir_b_not_yet", 64'(o_vld[1]), 64'd0);
        tick();
        check("dir_b_valid", 64'(o_vld[1]), 64'd1);
        check("dir_b_imm", o_imm[1], bi);
        check("dir_b_target", o_tgt[1], bt);
        check("dir_b_type", 64'(o_ty[1]), 64'(bty));
        check("dir_b_illegal", 64'(o_ill[1]), 64'(bil));
        drain();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  o;
        r = $urandom;
        o = ($urandom_range(0, 4) == 0) ? r[6:0] : opc_tab[$urandom_range(0, 12)];
        return {r[31:7], o};
    endfunction

    initial begin
        logic [31:0] bp_list [4];
        int          sent;
        int          b_before;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = '0; pc = '0; saw_stall = 1'b0;
        pop_cnt[0] = 0; pop_cnt[1] = 0;
        #1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        directed(32'hFFC10083, 64'h100, 64'hFFFFFFFC, 64'h0, 3'd1, 1'b0,
                 64'hFFFFFFFFFFFFFFFC, 64'h0, 3'd1, 1'b0);
        directed(32'hFE000EE3, 64'h200, 64'hFFFFFFFC, 64'h1FC, 3'd3, 1'b0,
                 64'hFFFFFFFFFFFFFFFC, 64'h1FC, 3'd3, 1'b0);
        directed(32'h0080006F, 64'h10, 64'h8, 64'h18, 3'd5, 1'b0,
                 64'h8, 64'h18, 3'd5, 1'b0);
        directed(32'h0010009B, 64'h0, 64'h0, 64'h0, 3'd0, 1'b1,
                 64'h1, 64'h0, 3'd1, 1'b0);
        directed(32'h800000B7, 64'h0, 64'h80000000, 64'h0, 3'd4, 1'b0,
                 64'hFFFFFFFF80000000, 64'h0, 3'd4, 1'b0);
        directed(32'h3401D073, 64'h0, 64'h3, 64'h0, 3'd6, 1'b0,
                 64'h0, 64'h0, 3'd0, 1'b0);
        directed(32'hFFFFF017, 64'h80, 64'hFFFFF000, 64'hFFFFF080, 3'd4, 1'b0,
                 64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFFFF080, 3'd4, 1'b0);
        directed(32'h0000007F, 64'h40, 64'h0, 64'h0, 3'd0, 1'b1,
                 64'h0, 64'h0, 3'd0, 1'b1);

        // Back-pressure: four distinct instructions, consumer stalls in cycles 3-5.
        bp_list[0] = 32'h00500093; bp_list[1] = 32'h00112223;
        bp_list[2] = 32'hFE000EE3; bp_list[3] = 32'h123450B7;
        sent = 0; saw_stall = 1'b0; b_before = pop_cnt[1];
        for (int c = 0; c < 12; c++) begin
            int qb;
            in_valid    = (sent < 4);
            instruction = bp_list[(sent < 4) ? sent : 3];
            pc          = 64'h1000 + 64'(sent * 4);
            out_ready   = !(c >= 3 && c <= 5);
            qb = q[1].size();
            tick();
            if (q[1].size() > qb - ((pop_cnt[1] > 0) ? 1 : 0) && in_valid && sent < 4) begin
                if (q[1].size() > 0 && q[1][q[1].size()-1].inst == bp_list[sent]
                    && int'(q[1][q[1].size()-1].acc) == edge_n) sent++;
            end
        end
        drain();
        check("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
        check("bp_all_emerged", 64'(pop_cnt[1] - b_before), 64'd4);

        // Flush with a simultaneous input while two entries are in flight.
        in_valid = 1'b1; out_ready = 1'b0; instruction = 32'h0080006F; pc = 64'h20;
        tick();
        instruction = 32'h00000013;
        tick();
        check("flush_pre_occupancy", 64'(q[1].size()), 64'd2);
        flush = 1'b1; instruction = 32'h800000B7;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_a_valid", 64'(o_vld[0]), 64'd0);
        check("flush_b_valid", 64'(o_vld[1]), 64'd0);
        drain();

        // Asynchronous reset with work in flight, then first post-reset latency.
        in_valid = 1'b1; out_ready = 1'b0; instruction = 32'h0080006F; pc = 64'h30;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_async_a_valid", 64'(o_vld[0]), 64'd0);
        check("rst_async_a_imm", o_imm[0], 64'd0);
        check("rst_async_b_valid", 64'(o_vld[1]), 64'd0);
        check("rst_async_b_imm", o_imm[1], 64'd0);
        q[0].delete(); q[1].delete();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        directed(32'hFFC10083, 64'h100, 64'hFFFFFFFC, 64'h0, 3'd1, 1'b0,
                 64'hFFFFFFFFFFFFFFFC, 64'h0, 3'd1, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 39) == 0);
            instruction = rand_inst();
            pc          = {$urandom, $urandom};
            tick();
        end
        drain();
        check("end_empty_a", 64'(q[0].size()), 64'd0);
        check("end_empty_b", 64'(q[1].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
